// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain sequencer.
//   drain_state_t     : sequencer states (IDLE, HDR, DATA, FILL)
//   FILL_BYTE_DEFAULT : byte returned when no sample data is owed
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    FILL
  } drain_state_t;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Handshake bundle between the drain sequencer, the sample FIFO read port and
// the I2C slave byte interface.
//   FIFO side : fifo_doutV, fifo_dout, fifo_cnt (to sequencer), fifo_doutR (pop)
//   I2C side  : txn_start, txn_stop, byte_req, clr_err (to sequencer),
//               byte_out, byte_valid, busy, underflow (from sequencer)
// master = the sequencer, slave = the surrounding FIFO / I2C logic.
interface fifo_drain_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int FIFOSIZE = 128
);
  localparam int CNTSIZE = $clog2(FIFOSIZE) + 1;

  logic                fifo_doutV;
  logic [DATASIZE-1:0] fifo_dout;
  logic [CNTSIZE-1:0]  fifo_cnt;
  logic                fifo_doutR;

  logic                txn_start;
  logic                txn_stop;
  logic                byte_req;
  logic [DATASIZE-1:0] byte_out;
  logic                byte_valid;
  logic                busy;
  logic                underflow;
  logic                clr_err;

  modport master (
    input  fifo_doutV, fifo_dout, fifo_cnt,
    output fifo_doutR,
    input  txn_start, txn_stop, byte_req, clr_err,
    output byte_out, byte_valid, busy, underflow
  );

  modport slave (
    output fifo_doutV, fifo_dout, fifo_cnt,
    input  fifo_doutR,
    output txn_start, txn_stop, byte_req, clr_err,
    input  byte_out, byte_valid, busy, underflow
  );

endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side sequencer between the DSP-to-I2C sample FIFO and the I2C slave.
// Each read transaction returns a header byte (FIFO count snapshotted at
// txn_start), then one FIFO entry per byte_req until the snapshot is used up,
// then FILL_BYTE. It is the only driver of the FIFO pop strobe.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : fifo_drain_ctrl_if.master (FIFO read port + I2C byte interface)
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int                  DATASIZE  = 8,
  parameter int                  FIFOSIZE  = 128,
  parameter logic [DATASIZE-1:0] FILL_BYTE = DATASIZE'(FILL_BYTE_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_drain_ctrl_if.master    bus
);

  localparam int CNTSIZE = $clog2(FIFOSIZE) + 1;
  localparam logic [CNTSIZE-1:0] MAX_CNT = CNTSIZE'(FIFOSIZE);

  if (CNTSIZE > DATASIZE) begin : g_width_check
    $fatal(1, "fifo_drain_ctrl: CNTSIZE (%0d) exceeds DATASIZE (%0d)", CNTSIZE, DATASIZE);
  end

  drain_state_t        state_q, state_d;
  logic [CNTSIZE-1:0]  remaining_q, remaining_d;
  logic [DATASIZE-1:0] byte_out_q, byte_out_d;
  logic                byte_valid_q, byte_valid_d;
  logic                underflow_q, underflow_d;
  logic                underflow_set;
  logic                pop;

  // Pop only when a request actually lands in DATA; stop/start win over it.
  assign pop = (state_q == DATA) && bus.byte_req && bus.fifo_doutV &&
               !bus.txn_stop && !bus.txn_start;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    underflow_set = 1'b0;

    if (bus.txn_stop) begin
      state_d = IDLE;
    end else if (bus.txn_start) begin
      state_d     = HDR;
      remaining_d = (bus.fifo_cnt > MAX_CNT) ? MAX_CNT : bus.fifo_cnt;
    end else if (bus.byte_req) begin
      byte_valid_d = 1'b1;
      unique case (state_q)
        IDLE: byte_out_d = FILL_BYTE;
        HDR: begin
          byte_out_d = DATASIZE'(remaining_q);
          state_d    = (remaining_q != '0) ? DATA : FILL;
        end
        DATA: begin
          if (bus.fifo_doutV) begin
            byte_out_d = bus.fifo_dout;
            if (remaining_q != '0) begin
              remaining_d = remaining_q - CNTSIZE'(1);
            end
            state_d = (remaining_q <= CNTSIZE'(1)) ? FILL : DATA;
          end else begin
            byte_out_d    = FILL_BYTE;
            underflow_set = 1'b1;
            state_d       = FILL;
          end
        end
        FILL: byte_out_d = FILL_BYTE;
        default: byte_out_d = FILL_BYTE;
      endcase
    end

    if (underflow_set) begin
      underflow_d = 1'b1;
    end else if (bus.clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      byte_out_q   <= FILL_BYTE;
      byte_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.fifo_doutR = pop;
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: behavioural FIFO, transaction-level
// reference model feeding an expected-byte queue, and a negedge monitor.
module tb_fifo_drain_ctrl;

  localparam int DATASIZE = 8;
  localparam int FIFOSIZE = 128;
  localparam int CNTSIZE  = $clog2(FIFOSIZE) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_drain_ctrl_if #(.DATASIZE(DATASIZE), .FIFOSIZE(FIFOSIZE)) bus ();

  fifo_drain_ctrl #(.DATASIZE(DATASIZE), .FIFOSIZE(FIFOSIZE), .FILL_BYTE(8'hFF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO contents (popped by the DUT's strobe).
  logic [7:0] fq[$];
  // Reference model: every byte ever written, and the model's read pointer.
  logic [7:0] written[$];
  int         rd_ptr = 0;
  bit         in_txn = 0;
  bit         hdr_pending = 0;
  int         owed = 0;
  bit         m_uf = 0;
  bit         force_empty = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.byte_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte_valid", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("byte_out", int'(bus.byte_out), int'(mon_exp));
      end
    end
  end

  task automatic refresh_fifo();
    bus.fifo_doutV = (fq.size() > 0) && !force_empty;
    bus.fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
    bus.fifo_cnt   = CNTSIZE'(fq.size());
  endtask

  // One clock of stimulus; the model predicts the response of this edge.
  task automatic step(input bit start, input bit stop, input bit req,
                      input bit wr, input logic [7:0] wd, input bit clr);
    int count;
    bit avail, exp_pop, uf_set, pop_seen, wr_ok;
    count = written.size() - rd_ptr;
    wr_ok = wr && (count < FIFOSIZE);
    bus.txn_start = start;
    bus.txn_stop  = stop;
    bus.byte_req  = req;
    bus.clr_err   = clr;
    refresh_fifo();
    avail   = (count > 0) && !force_empty;
    exp_pop = 0;
    uf_set  = 0;
    if (stop) begin
      in_txn = 0;
    end else if (start) begin
      in_txn      = 1;
      hdr_pending = 1;
      owed        = (count > FIFOSIZE) ? FIFOSIZE : count;
    end else if (req) begin
      if (!in_txn) begin
        exp_q.push_back(8'hFF);
      end else if (hdr_pending) begin
        exp_q.push_back(8'(owed));
        hdr_pending = 0;
      end else if (owed > 0) begin
        if (avail) begin
          exp_q.push_back(written[rd_ptr]);
          exp_pop = 1;
          owed--;
        end else begin
          exp_q.push_back(8'hFF);
          uf_set = 1;
          owed   = 0;
        end
      end else begin
        exp_q.push_back(8'hFF);
      end
    end
    m_uf = uf_set ? 1'b1 : (clr ? 1'b0 : m_uf);
    #1;
    chk("fifo_doutR", int'(bus.fifo_doutR), int'(exp_pop));
    pop_seen = bus.fifo_doutR;
    @(posedge clk);
    #1;
    if (pop_seen && fq.size() > 0) void'(fq.pop_front());
    if (wr_ok) fq.push_back(wd);
    if (exp_pop) rd_ptr++;
    if (wr_ok) written.push_back(wd);
    bus.txn_start = 0;
    bus.txn_stop  = 0;
    bus.byte_req  = 0;
    bus.clr_err   = 0;
    refresh_fifo();
    chk("busy", int'(bus.busy), int'(in_txn));
    chk("underflow", int'(bus.underflow), int'(m_uf));
  endtask

  task automatic wr_byte(input logic [7:0] d); step(0, 0, 0, 1, d, 0); endtask
  task automatic req1();  step(0, 0, 1, 0, 8'h00, 0); endtask
  task automatic start1(); step(1, 0, 0, 0, 8'h00, 0); endtask
  task automatic stop1(); step(0, 1, 0, 0, 8'h00, 0); endtask

  initial begin
    reset = 1;
    bus.txn_start = 0;
    bus.txn_stop  = 0;
    bus.byte_req  = 0;
    bus.clr_err   = 0;
    refresh_fifo();
    #1;
    chk("reset_byte_out", int'(bus.byte_out), 8'hFF);
    chk("reset_byte_valid", int'(bus.byte_valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_underflow", int'(bus.underflow), 0);
    chk("reset_doutR", int'(bus.fifo_doutR), 0);
    @(posedge clk);
    #1;
    reset = 0;

    // Snapshot and drain.
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    start1();
    for (int i = 0; i < 5; i++) req1();
    chk("drain_fifo_cnt", int'(bus.fifo_cnt), 0);
    stop1();

    // Empty FIFO.
    start1();
    req1(); req1();
    stop1();

    // Early stop and resume.
    for (int i = 0; i < 10; i++) wr_byte(8'h40 + 8'(i));
    start1();
    req1(); req1(); req1();
    stop1();
    chk("early_stop_fifo_cnt", int'(bus.fifo_cnt), 8);
    start1();
    req1(); req1();

    // Collisions: stop with a request in DATA, then repeated START in DATA.
    req1();
    step(0, 1, 1, 0, 8'h00, 0);
    start1();
    req1(); req1();
    step(1, 0, 1, 0, 8'h00, 0);
    req1();
    stop1();
    start1();
    for (int i = 0; i < 6; i++) req1();
    stop1();

    // Full FIFO with concurrent writes.
    for (int i = 0; i < FIFOSIZE; i++) wr_byte(8'($urandom));
    step(1, 0, 0, 1, 8'($urandom), 0);
    for (int i = 0; i < FIFOSIZE + 2; i++) step(0, 0, 1, 1, 8'($urandom), 0);
    stop1();
    start1();
    for (int i = 0; i < FIFOSIZE + 4 && (hdr_pending || owed > 0); i++) req1();
    stop1();

    // Forced underflow with two bytes still owed.
    for (int i = 0; i < 5; i++) wr_byte(8'hA0 + 8'(i));
    start1();
    req1(); req1(); req1(); req1();
    force_empty = 1;
    req1(); req1();
    step(0, 0, 0, 0, 8'h00, 1);
    force_empty = 0;
    stop1();

    // Async reset mid-DATA with underflow set.
    for (int i = 0; i < 4; i++) wr_byte(8'hC0 + 8'(i));
    start1();
    req1(); req1();
    force_empty = 1;
    req1();
    force_empty = 0;
    start1();
    req1(); req1();
    bus.byte_req = 1;
    #1;
    reset = 1;
    #1;
    chk("async_busy", int'(bus.busy), 0);
    chk("async_byte_valid", int'(bus.byte_valid), 0);
    chk("async_doutR", int'(bus.fifo_doutR), 0);
    chk("async_underflow", int'(bus.underflow), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("async_byte_out", int'(bus.byte_out), 8'hFF);
    bus.byte_req = 0;
    reset = 0;
    in_txn = 0; hdr_pending = 0; owed = 0; m_uf = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) force_empty = ~force_empty;
      step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
           8'($urandom), $urandom_range(0, 99) < 5);
    end
    force_empty = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
